// File: rtl/vram_responder.sv
// VRAM port owner: serves display word reads with priority over a CPU word port,
// sharing one synchronous array port with MEM_LAT read latency.
module vram_responder #(
    parameter int ADDR_W  = 15,
    parameter int MEM_LAT = 1,
    parameter int HOLDOFF = 2
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              vram_req,
    input  logic [ADDR_W-1:0] vram_addr,
    output logic [31:0]       vram_data,
    output logic              vram_ready,
    input  logic              cpu_req,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int HO_W  = $clog2(HOLDOFF + 2);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);
    localparam logic [HO_W-1:0]  HO_LOAD  = HO_W'(HOLDOFF + 1);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
            $error("vram_responder: MEM_LAT must be in 1..4");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DREAD  = 3'd1,
        DDONE  = 3'd2,
        CWRITE = 3'd3,
        CREAD  = 3'd4,
        CDONE  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [HO_W-1:0]   ho_q, ho_d;
    logic              cpu_rd_q, cpu_rd_d;
    logic [31:0]       vram_data_q, vram_data_d;
    logic              vram_ready_q, vram_ready_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              disp_elig;
    logic              cpu_elig;

    // The CPU still holds cpu_req during its ack cycle; only a request seen
    // after that cycle counts as a new access.
    assign disp_elig = vram_req && (ho_q == '0);
    assign cpu_elig  = cpu_req && !cpu_ack_q;

    always_comb begin
        state_d      = state_q;
        lat_d        = lat_q;
        ho_d         = (ho_q != '0) ? ho_q - 1'b1 : ho_q;
        cpu_rd_d     = cpu_rd_q;
        vram_data_d  = vram_data_q;
        vram_ready_d = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        cpu_ack_d    = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (disp_elig) begin
                    state_d    = DREAD;
                    mem_addr_d = vram_addr;
                    lat_d      = LAT_LOAD;
                end else if (cpu_elig) begin
                    mem_addr_d = cpu_addr;
                    if (cpu_write) begin
                        state_d     = CWRITE;
                        cpu_rd_d    = 1'b0;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = cpu_wdata;
                    end else begin
                        state_d  = CREAD;
                        cpu_rd_d = 1'b1;
                        lat_d    = LAT_LOAD;
                    end
                end
            end

            DREAD: begin
                if (lat_q == '0) begin
                    state_d = DDONE;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end

            // Loaded one above HOLDOFF: the ready cycle itself plus HOLDOFF
            // further cycles ignore the request the display is still holding.
            DDONE: begin
                vram_data_d  = mem_rdata;
                vram_ready_d = 1'b1;
                ho_d         = HO_LOAD;
                state_d      = IDLE;
            end

            CWRITE: begin
                state_d = CDONE;
            end

            CREAD: begin
                if (lat_q == '0) begin
                    state_d = CDONE;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end

            CDONE: begin
                if (cpu_rd_q) begin
                    cpu_rdata_d = mem_rdata;
                end
                cpu_ack_d = 1'b1;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            lat_q        <= '0;
            ho_q         <= '0;
            cpu_rd_q     <= 1'b0;
            vram_data_q  <= '0;
            vram_ready_q <= 1'b0;
            cpu_rdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            ho_q         <= ho_d;
            cpu_rd_q     <= cpu_rd_d;
            vram_data_q  <= vram_data_d;
            vram_ready_q <= vram_ready_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_ack_q    <= cpu_ack_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign vram_data  = vram_data_q;
    assign vram_ready = vram_ready_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_ack    = cpu_ack_q;
    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_vram_responder.sv
// Bench for vram_responder: synchronous VRAM model, display and CPU drivers,
// and a scoreboard monitor checking every vram_ready, cpu_ack and mem_we.
module tb_vram_responder;

    localparam int ADDR_W  = 15;
    localparam int MEM_LAT = 1;
    localparam int HOLDOFF = 2;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int LAT_NOM = MEM_LAT + 2;
    localparam int LAT_MAX = 2 * (MEM_LAT + 2);

    logic              vga_clk;
    logic              reset_n;
    logic              vram_req;
    logic [ADDR_W-1:0] vram_addr;
    logic [31:0]       vram_data;
    logic              vram_ready;
    logic              cpu_req;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    vram_responder #(
        .ADDR_W (ADDR_W),
        .MEM_LAT(MEM_LAT),
        .HOLDOFF(HOLDOFF)
    ) dut (
        .vga_clk   (vga_clk),
        .reset_n   (reset_n),
        .vram_req  (vram_req),
        .vram_addr (vram_addr),
        .vram_data (vram_data),
        .vram_ready(vram_ready),
        .cpu_req   (cpu_req),
        .cpu_write (cpu_write),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    int cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    function automatic logic [31:0] pre(int a);
        if (a == 5) return 32'hDEADBEEF;
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Synchronous VRAM array: read data appears MEM_LAT cycles after the address.
    logic [31:0] vmem    [0:DEPTH-1];
    logic [31:0] rd_pipe [0:MEM_LAT-1];
    initial begin
        for (int i = 0; i < DEPTH; i++) vmem[i] = pre(i);
        for (int i = 0; i < MEM_LAT; i++) rd_pipe[i] = '0;
        forever begin
            @(posedge vga_clk);
            if (mem_we) vmem[mem_addr] <= mem_wdata;
            rd_pipe[0] <= vmem[mem_addr];
            for (int i = MEM_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    typedef struct {
        logic [31:0] data;
        int          t0;
        int          lo;
        int          hi;
    } dexp_t;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } cexp_t;

    logic [31:0] ref_mem [0:DEPTH-1];
    dexp_t dq[$];
    cexp_t cq[$];
    int    n_vec = 0;
    int    n_fail = 0;
    int    n_dready = 0;
    int    n_cack = 0;
    int    n_we = 0;
    int    last_ready_cyc = 0;
    int    last_ack_cyc = 0;
    bit    prev_we = 1'b0;
    bit    stream_done = 1'b0;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endfunction

    function automatic void check_range(string nm, int v, int lo, int hi);
        n_vec++;
        if (v < lo || v > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, v, lo, hi);
        end
    endfunction

    function automatic void fail_now(string nm, string what);
        n_vec++;
        n_fail++;
        $display("FAIL %s: %s (cycle %0d)", nm, what, cyc);
    endfunction

    task automatic monitor();
        forever begin
            @(negedge vga_clk);
            if (!reset_n) begin
                prev_we = 1'b0;
            end else begin
                if (vram_ready) begin
                    n_dready++;
                    last_ready_cyc = cyc;
                    if (dq.size() == 0) begin
                        fail_now("vram_ready_unexpected", "got a pulse, expected none");
                    end else begin
                        dexp_t e = dq.pop_front();
                        check("vram_data", vram_data, e.data);
                        check_range("vram_latency", cyc - e.t0, e.lo, e.hi);
                    end
                end
                if (cpu_ack) begin
                    n_cack++;
                    last_ack_cyc = cyc;
                    if (cq.size() == 0) begin
                        fail_now("cpu_ack_unexpected", "got a pulse, expected none");
                    end else begin
                        cexp_t c = cq.pop_front();
                        if (!c.wr) check("cpu_rdata", cpu_rdata, c.data);
                    end
                end
                if (mem_we) begin
                    n_we++;
                    if (prev_we) fail_now("mem_we_width", "got mem_we for 2 cycles, expected 1");
                    if (cq.size() == 0 || !cq[0].wr) begin
                        fail_now("mem_we_unexpected", "got mem_we without a pending CPU write");
                    end else begin
                        check("mem_addr_on_write", 32'(mem_addr), 32'(cq[0].addr));
                        check("mem_wdata", mem_wdata, cq[0].data);
                    end
                end
                prev_we = mem_we;
            end
        end
    endtask

    task automatic disp_read(input logic [ADDR_W-1:0] a, input int lo, input int hi,
                             input int hold, input bit drop);
        dexp_t e;
        bit    seen;
        @(posedge vga_clk);
        #1;
        vram_req  = 1'b1;
        vram_addr = a;
        e.data = ref_mem[a];
        e.t0   = cyc;
        e.lo   = lo;
        e.hi   = hi;
        dq.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge vga_clk);
            if (vram_ready) seen = 1'b1;
        end
        if (!seen) begin
            fail_now("vram_ready_timeout", "no vram_ready within 64 cycles");
            if (dq.size() > 0) void'(dq.pop_back());
        end
        repeat (hold) @(posedge vga_clk);
        if (drop) begin
            @(posedge vga_clk);
            #1;
            vram_req = 1'b0;
        end
    endtask

    task automatic cpu_op(input bit wr, input logic [ADDR_W-1:0] a, input logic [31:0] d);
        cexp_t e;
        bit    seen;
        @(posedge vga_clk);
        #1;
        cpu_req   = 1'b1;
        cpu_write = wr;
        cpu_addr  = a;
        cpu_wdata = d;
        e.wr   = wr;
        e.addr = a;
        e.data = wr ? d : ref_mem[a];
        cq.push_back(e);
        if (wr) ref_mem[a] = d;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge vga_clk);
            if (cpu_ack) seen = 1'b1;
        end
        if (!seen) begin
            fail_now("cpu_ack_timeout", "no cpu_ack within 64 cycles");
            if (cq.size() > 0) void'(cq.pop_back());
        end
        @(posedge vga_clk);
        #1;
        cpu_req   = 1'b0;
        cpu_write = 1'b0;
    endtask

    task automatic check_outputs_zero(string tag);
        check({tag, "_vram_ready"}, 32'(vram_ready), 32'd0);
        check({tag, "_vram_data"}, vram_data, 32'd0);
        check({tag, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
        check({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int base_we;
        reset_n   = 1'b0;
        vram_req  = 1'b0;
        vram_addr = '0;
        cpu_req   = 1'b0;
        cpu_write = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = pre(i);
        fork
            monitor();
        join_none

        // Power-on reset state.
        repeat (3) @(posedge vga_clk);
        #1;
        check_outputs_zero("por");
        @(negedge vga_clk);
        reset_n = 1'b1;

        // Single display read of the preloaded word: ready exactly MEM_LAT+2 cycles in.
        disp_read(15'h0005, LAT_NOM, LAT_NOM, 0, 1'b1);
        check("read_held_data", vram_data, 32'hDEADBEEF);
        check("read_ready_low", 32'(vram_ready), 32'd0);
        repeat (4) @(posedge vga_clk);

        // Holdoff: req held 2 cycles past ready, then a new read at ready+3.
        base = n_dready;
        disp_read(15'h0100, LAT_NOM, LAT_NOM, 2, 1'b0);
        disp_read(15'h0101, LAT_NOM, LAT_NOM, 0, 1'b1);
        repeat (6) @(posedge vga_clk);
        check("holdoff_ready_count", 32'(n_dready - base), 32'd2);

        // Reset asserted in the middle of a display read.
        @(posedge vga_clk);
        #1;
        vram_req  = 1'b1;
        vram_addr = 15'h0123;
        @(posedge vga_clk);
        #3;
        reset_n  = 1'b0;
        vram_req = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        repeat (2) @(posedge vga_clk);
        @(negedge vga_clk);
        reset_n = 1'b1;
        base = n_dready;
        repeat (10) @(posedge vga_clk);
        #1;
        check("rst_no_ready_count", 32'(n_dready - base), 32'd0);
        check_outputs_zero("rst_after");

        // Simultaneous display and CPU read of the top address.
        fork
            disp_read(15'h0200, LAT_NOM, LAT_NOM, 0, 1'b1);
            cpu_op(1'b0, 15'h7FFF, 32'h0);
        join
        check("simul_ack_after_ready", 32'(last_ack_cyc - last_ready_cyc), 32'(MEM_LAT + 2));
        repeat (4) @(posedge vga_clk);

        // CPU write followed by display read of the same word.
        base_we = n_we;
        cpu_op(1'b1, 15'h0010, 32'h12345678);
        check("raw_we_pulses", 32'(n_we - base_we), 32'd1);
        repeat (2) @(posedge vga_clk);
        disp_read(15'h0010, LAT_NOM, LAT_NOM, 0, 1'b1);
        repeat (4) @(posedge vga_clk);

        // 32-word display stream against a stream of random CPU accesses.
        base = n_dready;
        fork
            begin
                for (int k = 0; k < 32; k++) begin
                    disp_read(ADDR_W'($urandom_range(0, 32'h0FFF)), LAT_NOM, LAT_MAX, 0, 1'b1);
                    repeat ($urandom_range(1, 3)) @(posedge vga_clk);
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    cpu_op($urandom_range(0, 3) != 0,
                           ADDR_W'(32'h4000 + $urandom_range(0, 255)), $urandom);
                    @(posedge vga_clk);
                end
            end
        join
        repeat (10) @(posedge vga_clk);
        check("stream_ready_count", 32'(n_dready - base), 32'd32);
        check("stream_dq_empty", 32'(dq.size()), 32'd0);
        check("stream_cq_empty", 32'(cq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
